// File: rtl/sdr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package  : sdr_pkg                                                 |
// | Purpose  : Shared width defaults and helpers for the SDR datapath. |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package sdr_pkg;

  localparam int DEF_INPUT_WIDTH = 12;
  localparam int DEF_DATA_WIDTH  = 12;
  localparam int DEF_MIX_WIDTH   = 16;
  localparam int DEF_DECIM       = 64;

  // Modulator full scale for a signed MIX_WIDTH input.
  function automatic int sd_full_scale(input int mix_w);
    return 1 << (mix_w - 1);
  endfunction

  // Right shift that maps the product difference onto MIX_WIDTH bits.
  function automatic int mix_shift(input int data_w, input int lo_w, input int mix_w);
    return data_w + lo_w + 1 - mix_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sigma_delta_mod.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : sigma_delta_mod                                         |
// | Purpose  : 1-bit sigma-delta modulator; SD_SECOND_ORDER_EN selects |
// |            the second-order loop, otherwise first-order.           |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module sigma_delta_mod
  import sdr_pkg::*;
#(
  parameter int MIX_WIDTH = DEF_MIX_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic signed [MIX_WIDTH-1:0] mix_in,
  output logic                        sd_out
);

`ifdef SD_SECOND_ORDER_EN
  localparam int ACC_W = MIX_WIDTH + 4;
`else
  localparam int ACC_W = MIX_WIDTH + 2;
`endif
  localparam logic signed [ACC_W-1:0] FS = ACC_W'(sd_full_scale(MIX_WIDTH));

  logic signed [ACC_W-1:0] mix_ext;
  logic signed [ACC_W-1:0] fb;
  logic signed [ACC_W-1:0] acc1_q, acc1_d;
  logic                    sd_q, sd_d;

  assign mix_ext = ACC_W'(mix_in);
  assign fb      = sd_q ? FS : -FS;
  assign sd_out  = sd_q;

`ifdef SD_SECOND_ORDER_EN
  logic signed [ACC_W-1:0] acc2_q, acc2_d;

  always_comb begin
    acc1_d = '0;
    acc2_d = '0;
    sd_d   = ~sd_q;
    if (enable) begin
      acc1_d = acc1_q + mix_ext - fb;
      acc2_d = acc2_q + acc1_d - fb;
      sd_d   = ~acc2_d[ACC_W-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc2_q <= '0;
    end else begin
      acc2_q <= acc2_d;
    end
  end
`else
  // Disabled: integrator cleared and output toggles for a zero-mean idle.
  always_comb begin
    acc1_d = '0;
    sd_d   = ~sd_q;
    if (enable) begin
      acc1_d = acc1_q + mix_ext - fb;
      sd_d   = ~acc1_d[ACC_W-1];
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc1_q <= '0;
      sd_q   <= 1'b0;
    end else begin
      acc1_q <= acc1_d;
      sd_q   <= sd_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tx_upmixer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tx_upmixer                                              |
// | Purpose  : Baseband I/Q upmixer (I*cos - Q*sin) feeding a 1-bit    |
// |            sigma-delta DAC; SD_SECOND_ORDER_EN selects 2nd order.  |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tx_upmixer
  import sdr_pkg::*;
#(
  parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int MIX_WIDTH   = DEF_MIX_WIDTH,
  parameter int DECIM       = DEF_DECIM
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic signed [DATA_WIDTH-1:0]  i_in,
  input  logic signed [DATA_WIDTH-1:0]  q_in,
  input  logic                          iq_valid,
  output logic                          iq_ready,
  input  logic signed [INPUT_WIDTH-1:0] sinewave_in,
  input  logic signed [INPUT_WIDTH-1:0] cosinewave_in,
  output logic signed [MIX_WIDTH-1:0]   mix_out,
  output logic                          sd_out,
  output logic                          underrun
);

  localparam int PROD_W = DATA_WIDTH + INPUT_WIDTH;
  localparam int SUM_W  = PROD_W + 1;
  localparam int SHIFT  = mix_shift(DATA_WIDTH, INPUT_WIDTH, MIX_WIDTH);
  localparam int CNT_W  = $clog2(DECIM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         rdy_q, rdy_d;
  logic                         underrun_q, underrun_d;
  logic signed [DATA_WIDTH-1:0] i_hold_q, i_hold_d;
  logic signed [DATA_WIDTH-1:0] q_hold_q, q_hold_d;
  logic signed [PROD_W-1:0]     p_i_q, p_i_d;
  logic signed [PROD_W-1:0]     p_q_q, p_q_d;
  logic signed [SUM_W-1:0]      sum;
  logic signed [MIX_WIDTH-1:0]  mix_q, mix_d;
  logic                         take;

  // Slot strobe is gated by enable so it drops in the same cycle enable falls.
  assign iq_ready = rdy_q & enable;
  assign take     = iq_ready & iq_valid;

  always_comb begin
    cnt_d      = '0;
    rdy_d      = 1'b0;
    i_hold_d   = i_hold_q;
    q_hold_d   = q_hold_q;
    underrun_d = underrun_q | (iq_ready & ~iq_valid);
    if (enable) begin
      rdy_d = (cnt_q == CNT_LAST);
      cnt_d = rdy_d ? '0 : cnt_q + CNT_W'(1);
    end
    if (take) begin
      i_hold_d = i_in;
      q_hold_d = q_in;
    end
  end

  assign p_i_d = PROD_W'(i_hold_q) * PROD_W'(cosinewave_in);
  assign p_q_d = PROD_W'(q_hold_q) * PROD_W'(sinewave_in);
  assign sum   = SUM_W'(p_i_q) - SUM_W'(p_q_q);
  // Arithmetic shift floors toward -inf; default widths cannot overflow MIX_WIDTH.
  assign mix_d = MIX_WIDTH'(sum >>> SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      rdy_q      <= 1'b0;
      underrun_q <= 1'b0;
      i_hold_q   <= '0;
      q_hold_q   <= '0;
      p_i_q      <= '0;
      p_q_q      <= '0;
      mix_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      rdy_q      <= rdy_d;
      underrun_q <= underrun_d;
      i_hold_q   <= i_hold_d;
      q_hold_q   <= q_hold_d;
      p_i_q      <= p_i_d;
      p_q_q      <= p_q_d;
      mix_q      <= mix_d;
    end
  end

  assign mix_out  = mix_q;
  assign underrun = underrun_q;

  sigma_delta_mod #(
    .MIX_WIDTH (MIX_WIDTH)
  ) u_sdm (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .mix_in (mix_q),
    .sd_out (sd_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_tx_upmixer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_tx_upmixer                                           |
// | Purpose  : Directed self-checking bench for tx_upmixer.            |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_tx_upmixer;

  localparam int DECIM = 64;
  localparam int FS    = 32768;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic               iq_valid;
  logic signed [11:0] i_in, q_in, sinewave_in, cosinewave_in;
  logic               iq_ready, sd_out, underrun;
  logic signed [15:0] mix_out;

  int n_checks = 0;
  int n_fail   = 0;

  int   m_acc1, m_acc2;
  logic m_sd;

  tx_upmixer #(
    .INPUT_WIDTH (12),
    .DATA_WIDTH  (12),
    .MIX_WIDTH   (16),
    .DECIM       (DECIM)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .i_in          (i_in),
    .q_in          (q_in),
    .iq_valid      (iq_valid),
    .iq_ready      (iq_ready),
    .sinewave_in   (sinewave_in),
    .cosinewave_in (cosinewave_in),
    .mix_out       (mix_out),
    .sd_out        (sd_out),
    .underrun      (underrun)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts edges until iq_ready is seen, bounded so a dead strobe cannot hang.
  task automatic wait_ready(input int start, output int n);
    n = start;
    do begin
      step(1);
      n++;
    end while (!iq_ready && n < start + 300);
  endtask

  task automatic count_ones(input int len, output int ones);
    ones = 0;
    repeat (len) begin
      step(1);
      if (sd_out) ones++;
    end
  endtask

  task automatic model_step(input int m);
    int fb;
    fb = m_sd ? FS : -FS;
`ifdef SD_SECOND_ORDER_EN
    m_acc1 = m_acc1 + m - fb;
    m_acc2 = m_acc2 + m_acc1 - fb;
    m_sd   = (m_acc2 >= 0);
`else
    m_acc1 = m_acc1 + m - fb;
    m_sd   = (m_acc1 >= 0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   ones;
    logic prev;

    rst = 1'b1; enable = 1'b0; iq_valid = 1'b0;
    i_in = '0; q_in = '0; sinewave_in = '0; cosinewave_in = '0;
    step(3);
    check_val("rst_iq_ready", iq_ready, 0);
    check_val("rst_mix_out",  mix_out,  0);
    check_val("rst_sd_out",   sd_out,   0);
    check_val("rst_underrun", underrun, 0);

    // DC tone: I=1024, cos=2047
    i_in = 12'sd1024; q_in = 12'sd0; cosinewave_in = 12'sd2047; sinewave_in = 12'sd0;
    iq_valid = 1'b1; enable = 1'b1;
    #4 rst = 1'b0;
    wait_ready(0, n);
    check_val("first_ready_latency", n, DECIM);
    step(1);
    check_val("ready_one_cycle", iq_ready, 0);
    step(3);
    check_val("dc_mix", mix_out, 4094);
    count_ones(4096, ones);
    $display("info: dc ones=%0d of 4096", ones);
    check_val("dc_density_window", (ones >= 2296 && ones <= 2312), 1);

    // Extremes: largest positive mix
    i_in = -12'sd2048; q_in = -12'sd2048; cosinewave_in = -12'sd2048; sinewave_in = 12'sd2047;
    wait_ready(0, n);
    step(4);
    check_val("ext_mix", mix_out, 16380);
    count_ones(4096, ones);
    $display("info: extreme ones=%0d of 4096", ones);
    check_val("ext_density_window", (ones >= 3062 && ones <= 3082), 1);
    check_val("ext_no_underrun", underrun, 0);

    // Underrun: holds keep -2048/-2048 while LO changes
    i_in = 12'sd1024; q_in = 12'sd0; cosinewave_in = 12'sd2047; sinewave_in = 12'sd0;
    iq_valid = 1'b0;
    wait_ready(0, n);
    step(4);
    check_val("udr_flag", underrun, 1);
    check_val("udr_hold_mix", mix_out, -8188);
    iq_valid = 1'b1;
    wait_ready(0, n);
    step(4);
    check_val("udr_recover_mix", mix_out, 4094);
    check_val("udr_sticky", underrun, 1);

    // Idle: toggle pattern, no strobe
    cosinewave_in = 12'sd0;
    enable = 1'b0;
    #1;
    check_val("idle_ready_gated", iq_ready, 0);
    prev = sd_out;
    for (int k = 0; k < 8; k++) begin
      step(1);
      check_val("idle_toggle", sd_out, !prev);
      check_val("idle_ready", iq_ready, 0);
      prev = sd_out;
    end
    check_val("idle_mix_zero", mix_out, 0);

    // Latency: LO step at enable rise, modulator restarts from acc=0
    enable = 1'b1;
    cosinewave_in = 12'sd2047;
    m_sd = sd_out; m_acc1 = 0; m_acc2 = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      model_step((k >= 3) ? 4094 : 0);
      check_val("lat_mix", mix_out, (k >= 2) ? 4094 : 0);
      check_val("lat_sd", sd_out, m_sd);
    end
    wait_ready(12, n);
    check_val("reenable_ready_latency", n, DECIM);

    // Mid-stream asynchronous reset at count=30
    step(30);
    #4 rst = 1'b1;
    #1;
    check_val("mid_rst_iq_ready", iq_ready, 0);
    check_val("mid_rst_mix_out",  mix_out,  0);
    check_val("mid_rst_sd_out",   sd_out,   0);
    check_val("mid_rst_underrun", underrun, 0);
    step(2);
    #4 rst = 1'b0;
    wait_ready(0, n);
    check_val("post_rst_ready_latency", n, DECIM);
    step(4);
    check_val("post_rst_mix", mix_out, 4094);
    check_val("post_rst_underrun", underrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
